rmw_word_adapter: RTL and testbench

- Sits between a CPU data master and a word-only RAM/bus slave that cannot do byte writes.
- Full-word writes pass straight through. Partial-byte writes become a read-modify-write (RMW) sequence.
- Generalises the earlier single-cycle byte converter: configurable data width and read latency, slave wait-state handshake, RMW statistics counter.

---
 rtl/rmw_word_adapter.sv | 155 +++++++++++++++
 tb/tb_rmw_word_adapter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_word_adapter.sv
// Byte-write adapter for a word-only slave: full-word writes pass through,
// partial-byte writes become a read-modify-write against the slave.
module rmw_word_adapter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_read,
  input  logic                  m_write,
  input  logic [DATA_W/8-1:0]   m_be,
  input  logic [ADDR_W-1:0]     m_addr,
  input  logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  m_stall,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_wait,
  output logic [CNT_W-1:0]      rmw_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_INIT = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, RMW_WR} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] merged_q;
  logic [DATA_W-1:0] merged_d;
  logic [DATA_W-1:0] src_wdata;
  logic [BE_W-1:0]   src_be;

  logic be_full;
  logic be_none;
  logic part_wr;

  assign be_full = &m_be;
  assign be_none = ~|m_be;
  assign part_wr = m_write & ~be_full & ~be_none;

  // With RD_LAT=0 the merge happens in the acceptance cycle, before the capture registers load.
  assign src_wdata = (state == IDLE) ? m_wdata : wdata_q;
  assign src_be    = (state == IDLE) ? m_be    : be_q;

  always_comb begin
    merged_d = '0;
    for (int i = 0; i < BE_W; i++) begin
      merged_d[8*i +: 8] = src_be[i] ? src_wdata[8*i +: 8] : ram_rdata[8*i +: 8];
    end
  end

  assign m_rdata = ram_rdata;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latches).
    ram_read  = 1'b0;
    ram_write = 1'b0;
    m_stall   = 1'b0;
    ram_addr  = m_addr;
    ram_wdata = m_wdata;
    unique case (state)
      IDLE: begin
        if (m_write) begin
          if (be_full) begin
            ram_write = 1'b1;
            m_stall   = ram_wait;
          end else if (!be_none) begin
            ram_read = 1'b1;
            m_stall  = 1'b1;
          end
        end else if (m_read) begin
          ram_read = 1'b1;
          m_stall  = (RD_LAT == 0) ? ram_wait : 1'b1;
        end
      end
      RD_WAIT:  m_stall = (lat_cnt != '0);
      RMW_WAIT: m_stall = 1'b1;
      RMW_WR: begin
        ram_write = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = merged_q;
        m_stall   = ram_wait;
      end
    endcase
    // Keep the slave quiet and the master free while held in reset.
    if (!rst_n) begin
      ram_read  = 1'b0;
      ram_write = 1'b0;
      m_stall   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: captured address/data/BE and merged word are reset too, so a post-reset state is fully defined.
      state     <= IDLE;
      lat_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      merged_q  <= '0;
      rmw_count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (part_wr && !ram_wait) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            be_q    <= m_be;
            if (RD_LAT == 0) begin
              merged_q <= merged_d;
              state    <= RMW_WR;
            end else begin
              lat_cnt <= LAT_INIT;
              state   <= RMW_WAIT;
            end
          end else if (!m_write && m_read && !ram_wait && (RD_LAT != 0)) begin
            lat_cnt <= LAT_INIT;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) state <= IDLE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        RMW_WAIT: begin
          if (lat_cnt == '0) begin
            merged_q <= merged_d;
            state    <= RMW_WR;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RMW_WR: begin
          if (!ram_wait) begin
            state <= IDLE;
            if (rmw_count != '1) rmw_count <= rmw_count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmw_word_adapter.sv
// Self-checking bench: two adapters (RD_LAT=0/CNT_W=16 and RD_LAT=2/CNT_W=2)
// checked every cycle against a transaction-timeline model of the slave protocol.
module tb_rmw_word_adapter;

  typedef enum {K_NONE, K_FULL, K_READ, K_PART} kind_e;

  typedef struct packed {
    logic        wt;
    logic        rd;
    logic        wr;
    logic        stall;
    logic        chk_addr;
    logic [31:0] addr;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        m_read    [2];
  logic        m_write   [2];
  logic [3:0]  m_be      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [31:0] m_rdata   [2];
  logic        m_stall   [2];
  logic        ram_read  [2];
  logic        ram_write [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];
  logic        ram_wait  [2];
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  logic [31:0] mem [256];
  logic [31:0] last_wr [2];
  logic [1:0]  pend_cnt = '0;
  logic [7:0]  pend_idx = '0;

  step_t exp_s  [2];
  logic  exp_on [2];
  int    mcnt   [2];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  rmw_word_adapter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .m_read(m_read[0]), .m_write(m_write[0]), .m_be(m_be[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .m_stall(m_stall[0]),
    .ram_read(ram_read[0]), .ram_write(ram_write[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .ram_wait(ram_wait[0]),
    .rmw_count(cnt_a));

  rmw_word_adapter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(2), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .m_read(m_read[1]), .m_write(m_write[1]), .m_be(m_be[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .m_stall(m_stall[1]),
    .ram_read(ram_read[1]), .ram_write(ram_write[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .ram_wait(ram_wait[1]),
    .rmw_count(cnt_b));

  // Slave models: zero-latency RAM for u_a; u_b gets data exactly two cycles after acceptance.
  assign ram_rdata[0] = ram_read[0] ? mem[ram_addr[0][9:2]] : 32'hBAD0_BAD0;
  assign ram_rdata[1] = (pend_cnt == 2'd1) ? mem[pend_idx] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (ram_read[1] && !ram_wait[1]) begin
      pend_cnt <= 2'd2;
      pend_idx <= ram_addr[1][9:2];
    end else if (pend_cnt != 2'd0) begin
      pend_cnt <= pend_cnt - 2'd1;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (ram_write[k] && !ram_wait[k]) last_wr[k] <= ram_wdata[k];
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_on[k]) begin
        check("ram_read", k, 32'(ram_read[k]), 32'(exp_s[k].rd));
        check("ram_write", k, 32'(ram_write[k]), 32'(exp_s[k].wr));
        check("m_stall", k, 32'(m_stall[k]), 32'(exp_s[k].stall));
        check("rmw_count", k, (k == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(mcnt[k]));
        if (exp_s[k].chk_addr)  check("ram_addr", k, ram_addr[k], exp_s[k].addr);
        if (exp_s[k].chk_wdata) check("ram_wdata", k, ram_wdata[k], exp_s[k].wdata);
        if (exp_s[k].chk_rdata) check("m_rdata", k, m_rdata[k], exp_s[k].rdata);
      end
    end
  end

  function automatic step_t blank();
    step_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [3:0] be, input logic [31:0] wd, input logic [31:0] old);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (wd & mask) | (old & ~mask);
  endfunction

  // Enters and leaves at 1 time unit after a rising edge.
  task automatic idle(input int k, input int n);
    m_read[k] = 1'b0; m_write[k] = 1'b0; m_be[k] = '0; ram_wait[k] = 1'b0;
    exp_s[k] = blank(); exp_on[k] = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Builds the expected per-cycle timeline of one master transaction, then plays it.
  task automatic run_txn(input int k, input kind_e kind, input logic both, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int w_cmd, input int w_wr);
    step_t q[$];
    step_t s;
    int lat;
    logic [31:0] old;
    lat = (k == 0) ? 0 : 2;
    old = mem[addr[9:2]];
    case (kind)
      K_NONE: q.push_back(blank());
      K_FULL:
        for (int i = 0; i <= w_cmd; i++) begin
          s = blank(); s.wt = (i < w_cmd); s.wr = 1'b1; s.stall = s.wt;
          s.chk_addr = 1'b1; s.addr = addr; s.chk_wdata = 1'b1; s.wdata = wd;
          q.push_back(s);
        end
      K_READ: begin
        for (int i = 0; i <= w_cmd; i++) begin
          s = blank(); s.wt = (i < w_cmd); s.rd = 1'b1; s.chk_addr = 1'b1; s.addr = addr;
          s.stall = (lat == 0) ? s.wt : 1'b1;
          if (lat == 0 && !s.wt) begin s.chk_rdata = 1'b1; s.rdata = old; end
          q.push_back(s);
        end
        for (int j = 1; j <= lat; j++) begin
          s = blank(); s.stall = (j < lat);
          if (j == lat) begin s.chk_rdata = 1'b1; s.rdata = old; end
          q.push_back(s);
        end
      end
      K_PART: begin
        for (int i = 0; i <= w_cmd; i++) begin
          s = blank(); s.wt = (i < w_cmd); s.rd = 1'b1; s.stall = 1'b1;
          s.chk_addr = 1'b1; s.addr = addr;
          q.push_back(s);
        end
        for (int j = 0; j < lat; j++) begin
          s = blank(); s.stall = 1'b1;
          q.push_back(s);
        end
        for (int i = 0; i <= w_wr; i++) begin
          s = blank(); s.wt = (i < w_wr); s.wr = 1'b1; s.stall = s.wt;
          s.chk_addr = 1'b1; s.addr = addr; s.chk_wdata = 1'b1; s.wdata = merge(be, wd, old);
          q.push_back(s);
        end
      end
      default: q.push_back(blank());
    endcase
    m_addr[k] = addr; m_be[k] = be; m_wdata[k] = wd;
    m_write[k] = (kind != K_READ);
    m_read[k]  = (kind == K_READ) || both;
    foreach (q[i]) begin
      ram_wait[k] = q[i].wt;
      exp_s[k] = q[i]; exp_on[k] = 1'b1;
      @(posedge clk); #1;
    end
    if (kind == K_PART && mcnt[k] < ((k == 0) ? 65535 : 3)) mcnt[k]++;
    idle(k, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[8'h41] = 32'h1122_3344;
    mem[8'h80] = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; m_read[k] = 1'b1; m_write[k] = 1'b1; m_be[k] = 4'hF;
      m_addr[k] = 32'h100; m_wdata[k] = '0; ram_wait[k] = 1'b0;
      exp_s[k] = blank(); exp_on[k] = 1'b1; mcnt[k] = 0; last_wr[k] = '0;
    end
    // Requests held high during reset must not reach the slave.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1; m_read[k] = 1'b0; m_write[k] = 1'b0; m_be[k] = '0;
    end
    idle(0, 2);

    run_txn(0, K_FULL, 1'b0, 32'h100, 4'hF, 32'hDEAD_BEEF, 0, 0);
    check("lit_full_wdata", 0, last_wr[0], 32'hDEAD_BEEF);
    run_txn(0, K_PART, 1'b0, 32'h104, 4'b0010, 32'hAABB_CCDD, 0, 0);
    check("lit_rmw_wdata", 0, last_wr[0], 32'h1122_CC44);
    check("lit_rmw_count", 0, 32'(cnt_a), 32'd1);
    run_txn(0, K_READ, 1'b0, 32'h200, 4'h0, 32'h0, 1, 0);
    run_txn(0, K_FULL, 1'b0, 32'h108, 4'hF, 32'h0BAD_CAFE, 2, 0);
    run_txn(0, K_NONE, 1'b0, 32'h10C, 4'h0, 32'hFFFF_FFFF, 0, 0);
    check("lit_none_count", 0, 32'(cnt_a), 32'd1);
    run_txn(0, K_PART, 1'b1, 32'h200, 4'b1001, 32'h0102_0304, 1, 2);
    check("lit_both_wdata", 0, last_wr[0], 32'h01FE_F004);
    run_txn(0, K_FULL, 1'b1, 32'h110, 4'hF, 32'h1357_9BDF, 0, 0);

    run_txn(1, K_PART, 1'b0, 32'h104, 4'b0010, 32'hAABB_CCDD, 2, 1);
    check("lit_rmw_lat2_wdata", 1, last_wr[1], 32'h1122_CC44);
    run_txn(1, K_READ, 1'b0, 32'h200, 4'h0, 32'h0, 0, 0);
    run_txn(1, K_READ, 1'b0, 32'h104, 4'h0, 32'h0, 2, 0);
    for (int n = 0; n < 4; n++)
      run_txn(1, K_PART, 1'b0, 32'h100 + 32'(4 * n), 4'b0101 << (n % 2), 32'h7788_99AA + 32'(n), n % 2, 0);
    check("lit_sat_count", 1, 32'(cnt_b), 32'd3);

    // Reset while the RMW waits for read data: the write must never issue.
    m_addr[1] = 32'h104; m_be[1] = 4'b0010; m_wdata[1] = 32'hAABB_CCDD;
    m_write[1] = 1'b1; m_read[1] = 1'b0; ram_wait[1] = 1'b0;
    s = blank(); s.rd = 1'b1; s.stall = 1'b1; s.chk_addr = 1'b1; s.addr = 32'h104;
    exp_s[1] = s;
    @(posedge clk); #1;
    s = blank(); s.stall = 1'b1;
    exp_s[1] = s;
    @(negedge clk); #1;
    rst_n[1] = 1'b0; m_write[1] = 1'b0; m_be[1] = '0; mcnt[1] = 0;
    exp_s[1] = blank();
    repeat (2) begin @(posedge clk); #1; end
    rst_n[1] = 1'b1;
    idle(1, 4);
    check("lit_reset_count", 1, 32'(cnt_b), 32'd0);
    run_txn(1, K_PART, 1'b0, 32'h200, 4'b1000, 32'h99AA_BBCC, 0, 0);
    check("lit_post_reset_count", 1, 32'(cnt_b), 32'd1);
    idle(1, 2);

    exp_on[0] = 1'b0; exp_on[1] = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
